// File: rtl/ser_pkg.sv
// Shared types and helpers for the byte serializer.
// State encodings and the counter-width function.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable bit-position counter for the serializer.
// tc flags the last data bit (cnt == WIDTH-1).
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(WIDTH - 1));

  // Clear on load, otherwise count up and hold at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-in serial-out stage with first/last framing.
// Optional even parity bit: BYTE_SERIALIZER_PARITY_EN.
module byte_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_out,
  output logic             shift_en,
  output logic             shift_first,
  output logic             shift_last,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);
  localparam bit MF = (MSB_FIRST != 0);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             ld;
  logic             inc;
  logic             out_n;
  logic             en_n;
  logic             first_n;
  logic             last_n;
  logic             first_bit;
  logic             next_bit;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .inc  (inc),
    .cnt  (cnt),
    .tc   (tc)
  );

`ifdef BYTE_SERIALIZER_PARITY_EN
  assign in_ready = (state == ST_IDLE) ||
                    (state == ST_PAR);
`else
  assign in_ready = (state == ST_IDLE) ||
                    ((state == ST_SHIFT) && tc);
`endif

  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign first_bit = MF ? in_data[WIDTH-1]
                        : in_data[0];
  assign next_bit  = MF ? sreg[WIDTH-2]
                        : sreg[1];

  // Next state, counter control and next registered outputs.
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    inc     = 1'b0;
    out_n   = 1'b0;
    en_n    = 1'b0;
    first_n = 1'b0;
    last_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_n = ST_IDLE;
      end
      ST_SHIFT: begin
        if (!tc) begin
          inc   = 1'b1;
          en_n  = 1'b1;
          out_n = next_bit;
`ifdef BYTE_SERIALIZER_PARITY_EN
          last_n = 1'b0;
`else
          last_n = (cnt == CW'(WIDTH - 2));
`endif
        end else begin
`ifdef BYTE_SERIALIZER_PARITY_EN
          state_n = ST_PAR;
          en_n    = 1'b1;
          out_n   = par_q;
          last_n  = 1'b1;
`else
          state_n = ST_IDLE;
`endif
        end
      end
`ifdef BYTE_SERIALIZER_PARITY_EN
      ST_PAR: begin
        state_n = ST_IDLE;
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (accept) begin
      state_n = ST_SHIFT;
      out_n   = first_bit;
      en_n    = 1'b1;
      first_n = 1'b1;
      last_n  = 1'b0;
    end
    ld = accept || (state_n == ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Word register: load on accept, shift toward the output end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= in_data;
    end else if (inc) begin
      sreg <= MF ? {sreg[WIDTH-2:0], 1'b0}
                 : {1'b0, sreg[WIDTH-1:1]};
    end
  end

`ifdef BYTE_SERIALIZER_PARITY_EN
  // Parity is captured at accept since shifting destroys the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^in_data;
    end
  end
`endif

  // Registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_out   <= 1'b0;
      shift_en    <= 1'b0;
      shift_first <= 1'b0;
      shift_last  <= 1'b0;
    end else begin
      shift_out   <= out_n;
      shift_en    <= en_n;
      shift_first <= first_n;
      shift_last  <= last_n;
    end
  end

endmodule
